level_bcd_converter: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3 / double-dabble) for the game level.

---
 rtl/level_bcd_converter.sv | 121 ++++++++++++
 tb/tb_level_bcd_converter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/level_bcd_converter.sv
// Sequential shift-add-3 binary-to-BCD converter for the game level.
// Outputs change only on the Done cycle; scratch digits stay internal.
module level_bcd_converter #(
  parameter int BIN_W       = 7,
  parameter int MAX_VAL     = 99,
  parameter bit AUTO_UPDATE = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [BIN_W-1:0] Bin_in,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       Tens,
  output logic [3:0]       Ones,
  output logic             Ovf
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_VAL);
  localparam logic [CW-1:0] LAST_CNT = CW'(BIN_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]    cnt_q;
  logic [BIN_W-1:0] op_q;
  logic [BIN_W-1:0] last_q;
  logic [3:0]       st_q;
  logic [3:0]       so_q;
  logic             ovf_q;

  logic             launch;
  logic             last_step;
  logic             over;
  logic [3:0]       adj_t;
  logic [3:0]       adj_o;
  logic [3:0]       st_d;
  logic [3:0]       so_d;
  logic [BIN_W-1:0] op_d;

  assign over      = (Bin_in > MAX_B);
  assign launch    = Start | (AUTO_UPDATE && (Bin_in != last_q));
  assign last_step = (cnt_q == LAST_CNT);
  assign Busy      = (state_q == SHIFT);

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: launch from IDLE, return after BIN_W shift edges
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (launch)    state_d = SHIFT;
      SHIFT: if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One double-dabble step: add-3 correction, then shift left by one
  always_comb begin
    adj_t = (st_q >= 4'd5) ? st_q + 4'd3 : st_q;
    adj_o = (so_q >= 4'd5) ? so_q + 4'd3 : so_q;
    st_d  = (adj_t << 1) | {3'b000, adj_o[3]};
    so_d  = (adj_o << 1) | {3'b000, op_q[BIN_W-1]};
    op_d  = op_q << 1;
  end

  // Datapath: capture operand at launch, shift, publish on last step
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q  <= '0;
      op_q   <= '0;
      last_q <= '0;
      st_q   <= '0;
      so_q   <= '0;
      ovf_q  <= 1'b0;
      Done   <= 1'b0;
      Tens   <= '0;
      Ones   <= '0;
      Ovf    <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            op_q   <= over ? MAX_B : Bin_in;
            ovf_q  <= over;
            last_q <= Bin_in;
            st_q   <= '0;
            so_q   <= '0;
            cnt_q  <= '0;
          end
        end
        SHIFT: begin
          st_q  <= st_d;
          so_q  <= so_d;
          op_q  <= op_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            cnt_q <= '0;
            Tens  <= st_d;
            Ones  <= so_d;
            Ovf   <= ovf_q;
            Done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_level_bcd_converter.sv
// Directed bench for level_bcd_converter.
// Auto-update and start-only instances share clock and reset.
module tb_level_bcd_converter;

  logic       Clk;
  logic       Reset;
  logic [6:0] Bin_in;
  logic       Start;
  logic       Busy;
  logic       Done;
  logic [3:0] Tens;
  logic [3:0] Ones;
  logic       Ovf;

  logic [6:0] Bin_in0;
  logic       Start0;
  logic       Busy0;
  logic       Done0;
  logic [3:0] Tens0;
  logic [3:0] Ones0;
  logic       Ovf0;

  int total;
  int fails;
  int lat;
  int dcnt;

  level_bcd_converter #(
    .BIN_W(7), .MAX_VAL(99), .AUTO_UPDATE(1'b1)
  ) u_dut (
    .Clk(Clk), .Reset(Reset), .Bin_in(Bin_in), .Start(Start),
    .Busy(Busy), .Done(Done), .Tens(Tens), .Ones(Ones), .Ovf(Ovf)
  );

  level_bcd_converter #(
    .BIN_W(7), .MAX_VAL(99), .AUTO_UPDATE(1'b0)
  ) u_dut0 (
    .Clk(Clk), .Reset(Reset), .Bin_in(Bin_in0), .Start(Start0),
    .Busy(Busy0), .Done(Done0), .Tens(Tens0), .Ones(Ones0), .Ovf(Ovf0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launch on the auto-update instance and wait for Done
  task automatic conv(input logic [6:0] v, input logic s, output int l);
    Bin_in = v;
    Start  = s;
    step();
    Start = 1'b0;
    l = 0;
    while (Done !== 1'b1 && l < 30) begin
      step();
      l++;
    end
  endtask

  // Start-only instance
  task automatic conv0(input logic [6:0] v, output int l);
    Bin_in0 = v;
    Start0  = 1'b1;
    step();
    Start0 = 1'b0;
    l = 0;
    while (Done0 !== 1'b1 && l < 30) begin
      step();
      l++;
    end
  endtask

  initial begin
    total   = 0;
    fails   = 0;
    Reset   = 1'b0;
    Bin_in  = '0;
    Start   = 1'b0;
    Bin_in0 = '0;
    Start0  = 1'b0;

    // 1: reset, release with Bin_in=0, nothing happens
    step();
    step();
    chk("rst_busy", Busy, 1'b0);
    chk("rst_tens", Tens, 4'd0);
    Reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (Done === 1'b1 || Busy === 1'b1) dcnt++;
    end
    chk("idle_no_activity", dcnt, 0);
    chk("idle_tens", Tens, 4'd0);
    chk("idle_ones", Ones, 4'd0);
    chk("idle_ovf", Ovf, 1'b0);

    // 2: 42 with Start, cycle-exact Busy/Done
    Bin_in = 7'd42;
    Start  = 1'b1;
    step();
    Start = 1'b0;
    chk("c42_busy_k", Busy, 1'b1);
    dcnt = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (Busy !== 1'b1 || Done !== 1'b0 || Tens !== 4'd0) dcnt++;
    end
    chk("c42_busy_span", dcnt, 0);
    step();
    chk("c42_done", Done, 1'b1);
    chk("c42_busy_end", Busy, 1'b0);
    chk("c42_tens", Tens, 4'd4);
    chk("c42_ones", Ones, 4'd2);
    chk("c42_ovf", Ovf, 1'b0);
    step();
    chk("c42_done_1cyc", Done, 1'b0);

    // 3: saturation, then 99 by auto-update
    conv(7'd127, 1'b1, lat);
    chk("c127_lat", lat, 7);
    chk("c127_tens", Tens, 4'd9);
    chk("c127_ones", Ones, 4'd9);
    chk("c127_ovf", Ovf, 1'b1);
    step();
    conv(7'd99, 1'b0, lat);
    chk("c99_lat", lat, 7);
    chk("c99_tens", Tens, 4'd9);
    chk("c99_ones", Ones, 4'd9);
    chk("c99_ovf", Ovf, 1'b0);
    step();

    // 4: input change mid-conversion is deferred
    Bin_in = 7'd15;
    Start  = 1'b1;
    step();
    Start = 1'b0;
    dcnt = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 3) Bin_in = 7'd37;
      step();
      if (Busy !== 1'b1 || Done !== 1'b0) dcnt++;
      if (Tens !== 4'd9 || Ones !== 4'd9) dcnt++;
    end
    chk("c15_no_tear", dcnt, 0);
    step();
    chk("c15_done", Done, 1'b1);
    chk("c15_tens", Tens, 4'd1);
    chk("c15_ones", Ones, 4'd5);
    step();
    chk("c37_relaunch", Busy, 1'b1);
    lat = 0;
    while (Done !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
    chk("c37_lat", lat, 7);
    chk("c37_tens", Tens, 4'd3);
    chk("c37_ones", Ones, 4'd7);
    step();

    // Start held high: one conversion per 8 cycles
    Start = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (Done === 1'b1) dcnt++;
    end
    Start = 1'b0;
    chk("held_done_cnt", dcnt, 2);
    step();
    chk("held_idle", Busy, 1'b0);

    // 5: reset mid-conversion
    conv(7'd88, 1'b1, lat);
    chk("c88_tens", Tens, 4'd8);
    chk("c88_ones", Ones, 4'd8);
    step();
    Bin_in = 7'd63;
    step();
    chk("c63_launch", Busy, 1'b1);
    step();
    step();
    step();
    #2;
    Reset = 1'b0;
    #1;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_tens", Tens, 4'd0);
    chk("abort_ones", Ones, 4'd0);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (Done !== 1'b0) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    Reset = 1'b1;
    step();
    chk("c63_auto", Busy, 1'b1);
    lat = 0;
    while (Done !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
    chk("c63_lat", lat, 7);
    chk("c63_tens", Tens, 4'd6);
    chk("c63_ones", Ones, 4'd3);

    // 6: Start-only instance never self-starts
    Bin_in0 = 7'd5;
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (Busy0 !== 1'b0) dcnt++;
    end
    chk("noauto_idle", dcnt, 0);

    // Sweep 0..127 on the Start-only instance
    for (int v = 0; v < 128; v++) begin
      int sat;
      sat = (v > 99) ? 99 : v;
      conv0(7'(v), lat);
      chk($sformatf("sw%0d_lat", v), lat, 7);
      chk($sformatf("sw%0d_tens", v), Tens0, 32'(sat / 10));
      chk($sformatf("sw%0d_ones", v), Ones0, 32'(sat % 10));
      chk($sformatf("sw%0d_ovf", v), Ovf0, 32'(v > 99));
      step();
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
